pe_pk32bit: RTL and testbench
=============================

Name: pe_pk32bit

Overview:
- Packing stage; the inverse of the lane-copy stage that writes each lane's low 32-bit word into both halves of a 64-bit lane.
- Takes a stream of 8-lane x 64-bit beats and keeps only bits [31:0] of each lane.
- Pairs two consecutive beats into one dense 8 x 64-bit output beat. Output bandwidth is half the input bandwidth at full density.
- Optionally checks that incoming lanes really are duplicated words, and supports flushing an odd trailing beat.

Parameters:
- CHECK_DUP, 1: enables the per-lane check that bits [63:32] equal bits [31:0]. When 0, DUP_ERR is held at 0.
- PAD, 32'h0000_0000: filler word for the upper half of a flushed partial beat.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- PEPKIN  input  [7:0][63:0]  input lanes; only [31:0] is carried forward.
- D_VALID  input  1  PEPKIN is valid this cycle.
- FLUSH  input  1  emit any held half-beat now, padded.
- ERR_CLR  input  1  synchronous clear of DUP_ERR.
- PEPKOUT  output  [7:0][63:0]  packed lanes: {second word, first word}.
- Q_VALID  output  1  one-cycle pulse marking PEPKOUT valid.
- Q_PARTIAL  output  1  qualifies Q_VALID; upper halves are PAD.
- DUP_ERR  output  [7:0]  sticky per-lane duplicate-mismatch flags.

Behaviour:
- All outputs are registered. Reset is asynchronous on RST high, and sets:
  - PEPKOUT = 0, Q_VALID = 0, Q_PARTIAL = 0, DUP_ERR = 0;
  - phase = EVEN;
  - hold register = 0.
- No backpressure. Every beat with D_VALID high is accepted. There is no ready signal.
- Phase FSM has two states: EVEN (nothing held) and ODD (hold holds 8 x 32-bit first words).
- EVEN, D_VALID=1, FLUSH=0:
  - hold[i] <= PEPKIN[i][31:0];
  - go to ODD;
  - no output.
- ODD, D_VALID=1, regardless of FLUSH:
  - PEPKOUT[i] <= {PEPKIN[i][31:0], hold[i]};
  - Q_VALID <= 1, Q_PARTIAL <= 0;
  - go to EVEN.
  - The pair completes normally; a FLUSH in the same cycle has nothing left to emit.
- ODD, D_VALID=0, FLUSH=1:
  - PEPKOUT[i] <= {PAD, hold[i]};
  - Q_VALID <= 1, Q_PARTIAL <= 1;
  - go to EVEN.
- EVEN, D_VALID=1, FLUSH=1:
  - PEPKOUT[i] <= {PAD, PEPKIN[i][31:0]};
  - Q_VALID <= 1, Q_PARTIAL <= 1;
  - stay in EVEN.
- EVEN, FLUSH=1, D_VALID=0: no effect.
- ODD, D_VALID=0, FLUSH=0: hold retained indefinitely, with no timeout.
- Latency: the output appears on the cycle after the completing (or flushing) beat is accepted.
- Q_VALID and Q_PARTIAL are 0 on every cycle without an emit.
- PEPKOUT holds its last value when Q_VALID is 0.
- Word order: the first-accepted word goes in [31:0] and the second in [63:32], per lane independently. All 8 lanes share one phase.
- DUP_ERR:
  - When CHECK_DUP=1 and D_VALID=1 and PEPKIN[i][63:32] != PEPKIN[i][31:0], DUP_ERR[i] <= 1. It is sticky.
  - ERR_CLR=1 clears all bits, except that a new mismatch in the same cycle wins (that bit is set).
  - The check runs in both phases, including flushed beats.
- Reset mid-pair discards the held half-beat silently; nothing is emitted.

Decomposition:
- Shared package pe_pkg:
  - constants PE_LANES = 8, PE_W = 64, PE_HW = 32;
  - typedef pe_lane_t = logic [PE_W-1:0];
  - typedef pe_beat_t = pe_lane_t [PE_LANES-1:0];
  - typedef pe_half_t = logic [PE_HW-1:0].
- Single module with no sub-module. Lane logic is a generate loop over PE_LANES. The phase FSM is one enum {EVEN, ODD}, defined locally.

Test Plan:
- Reset, then two D_VALID beats with lane i = {32'hA0+i, 32'hA0+i} followed by {32'hB0+i, 32'hB0+i} -> one Q_VALID pulse a cycle after the second beat; PEPKOUT[i] = {32'hB0+i, 32'hA0+i}; Q_PARTIAL = 0; DUP_ERR = 0.
- Continuous D_VALID for 6 beats -> exactly 3 Q_VALID pulses, on alternate cycles, with word order preserved; gaps of 1-5 idle cycles between the beats of a pair do not change the result.
- One beat {X, 32'h1234_5678} then FLUSH alone -> PEPKOUT[i] = {32'h0, 32'h1234_5678}, Q_PARTIAL = 1; a later pair is unaffected.
- FLUSH together with D_VALID, in EVEN and in ODD -> EVEN gives a partial emit of the new word; ODD gives a normal full pair with Q_PARTIAL = 0.
- Lane 3 input {32'hDEAD_0000, 32'h0000_0000} -> DUP_ERR = 8'h08 and stays set; ERR_CLR gives 0; ERR_CLR coincident with a new lane-3 mismatch leaves bit 3 at 1; with CHECK_DUP = 0, DUP_ERR stays 0.
- Assert RST while in ODD, then release and send one pair -> no emit for the discarded word; the pair packs correctly; all outputs read 0 during reset.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared lane/beat geometry for the pack/unpack pipeline stages.
package pe_pkg;

  localparam int unsigned PE_LANES = 8;
  localparam int unsigned PE_W     = 64;
  localparam int unsigned PE_HW    = 32;

  typedef logic [PE_W-1:0]           pe_lane_t;
  typedef pe_lane_t [PE_LANES-1:0]   pe_beat_t;
  typedef logic [PE_HW-1:0]          pe_half_t;

endpackage

// File: rtl/pe_pk32bit.sv
// Packs the low words of two consecutive 8-lane beats into one dense beat,
// with optional duplicated-word checking and padded flush of an odd beat.
module pe_pk32bit
  import pe_pkg::*;
#(
  parameter bit       CHECK_DUP = 1'b1,
  parameter pe_half_t PAD       = '0
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [PE_LANES-1:0][PE_W-1:0]    PEPKIN,
  input  logic                             D_VALID,
  input  logic                             FLUSH,
  input  logic                             ERR_CLR,
  output logic [PE_LANES-1:0][PE_W-1:0]    PEPKOUT,
  output logic                             Q_VALID,
  output logic                             Q_PARTIAL,
  output logic [PE_LANES-1:0]              DUP_ERR
);

  typedef enum logic {EVEN, ODD} phase_t;

  phase_t phase;
  logic   load;
  logic   emit_pair;
  logic   emit_held;
  logic   emit_new;

  // Decode the four phase/input cases once; every lane shares them.
  always_comb begin
    load      = 1'b0;
    emit_pair = 1'b0;
    emit_held = 1'b0;
    emit_new  = 1'b0;
    unique case (phase)
      EVEN: begin
        load     = D_VALID && !FLUSH;
        emit_new = D_VALID && FLUSH;
      end
      ODD: begin
        emit_pair = D_VALID;
        emit_held = !D_VALID && FLUSH;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      phase     <= EVEN;
      Q_VALID   <= 1'b0;
      Q_PARTIAL <= 1'b0;
    end else begin
      Q_VALID   <= emit_pair || emit_held || emit_new;
      Q_PARTIAL <= emit_held || emit_new;
      unique case (phase)
        EVEN: if (load)                    phase <= ODD;
        ODD:  if (emit_pair || emit_held)  phase <= EVEN;
      endcase
    end
  end

  for (genvar i = 0; i < PE_LANES; i++) begin : g_lane
    pe_half_t lo;
    pe_half_t hi;
    pe_half_t hold;
    pe_lane_t out_q;
    logic     err_q;
    logic     mismatch;

    assign lo       = PEPKIN[i][PE_HW-1:0];
    assign hi       = PEPKIN[i][PE_W-1:PE_HW];
    assign mismatch = CHECK_DUP && D_VALID && (hi != lo);

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        hold  <= '0;
        out_q <= '0;
        err_q <= 1'b0;
      end else begin
        if (load)
          hold <= lo;

        if (emit_pair)
          out_q <= {lo, hold};
        else if (emit_held)
          out_q <= {PAD, hold};
        else if (emit_new)
          out_q <= {PAD, lo};

        // A fresh mismatch outranks a same-cycle clear.
        if (mismatch)
          err_q <= 1'b1;
        else if (ERR_CLR)
          err_q <= 1'b0;
      end
    end

    assign PEPKOUT[i] = out_q;
    assign DUP_ERR[i] = err_q;
  end

endmodule

// File: tb/tb_pe_pk32bit.sv
// Self-checking bench for pe_pk32bit: directed vector table, hand sequences,
// and random traffic against a queue-based packing model.
module tb_pe_pk32bit;
  import pe_pkg::*;

  localparam logic [31:0] PAD_B  = 32'hCAFE_F00D;
  localparam logic [31:0] HI_BAD = 32'hDEAD_0000;

  typedef logic [7:0][63:0] beat_t;
  typedef logic [7:0][31:0] words_t;

  logic        CLK = 1'b0;
  logic        RST;
  beat_t       PEPKIN;
  logic        D_VALID, FLUSH, ERR_CLR;
  beat_t       out_a, out_b;
  logic        qv_a, qv_b, qp_a, qp_b;
  logic [7:0]  err_a, err_b;

  int vecs = 0;
  int miscomp = 0;

  // Model state
  words_t      pend[$];
  beat_t       exp_a, exp_b;
  logic        e_qv, e_qp;
  logic [7:0]  e_err;

  pe_pk32bit #(.CHECK_DUP(1'b1), .PAD(32'h0000_0000)) dut_a (
    .CLK(CLK), .RST(RST), .PEPKIN(PEPKIN), .D_VALID(D_VALID), .FLUSH(FLUSH),
    .ERR_CLR(ERR_CLR), .PEPKOUT(out_a), .Q_VALID(qv_a), .Q_PARTIAL(qp_a),
    .DUP_ERR(err_a));

  pe_pk32bit #(.CHECK_DUP(1'b0), .PAD(PAD_B)) dut_b (
    .CLK(CLK), .RST(RST), .PEPKIN(PEPKIN), .D_VALID(D_VALID), .FLUSH(FLUSH),
    .ERR_CLR(ERR_CLR), .PEPKOUT(out_b), .Q_VALID(qv_b), .Q_PARTIAL(qp_b),
    .DUP_ERR(err_b));

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] expv);
    vecs++;
    if (act !== expv) begin
      miscomp++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    exp_a = '0;
    exp_b = '0;
    e_qv  = 1'b0;
    e_qp  = 1'b0;
    e_err = '0;
  endtask

  // Words queue up; two queued words form a pair, a flush drains a lone one.
  task automatic model_clk();
    words_t w;
    for (int i = 0; i < 8; i++) w[i] = PEPKIN[i][31:0];
    e_qv = 1'b0;
    e_qp = 1'b0;
    if (D_VALID) pend.push_back(w);
    if (pend.size() == 2) begin
      for (int i = 0; i < 8; i++) begin
        exp_a[i] = {pend[1][i], pend[0][i]};
        exp_b[i] = {pend[1][i], pend[0][i]};
      end
      e_qv = 1'b1;
      pend.delete();
    end else if (FLUSH && pend.size() == 1) begin
      for (int i = 0; i < 8; i++) begin
        exp_a[i] = {32'h0, pend[0][i]};
        exp_b[i] = {PAD_B, pend[0][i]};
      end
      e_qv = 1'b1;
      e_qp = 1'b1;
      pend.delete();
    end
    for (int i = 0; i < 8; i++) begin
      if (D_VALID && PEPKIN[i][63:32] != PEPKIN[i][31:0]) e_err[i] = 1'b1;
      else if (ERR_CLR) e_err[i] = 1'b0;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".pepkout_a"}, out_a, exp_a);
    chk({tag, ".pepkout_b"}, out_b, exp_b);
    chk({tag, ".q_valid"},   {qv_b, qv_a}, {e_qv, e_qv});
    chk({tag, ".q_partial"}, {qp_b, qp_a}, {e_qp, e_qp});
    chk({tag, ".dup_err_a"}, err_a, e_err);
    chk({tag, ".dup_err_b"}, err_b, 8'h00);
  endtask

  task automatic step(input bit dv, input bit fl, input bit clr, input beat_t d, input string tag);
    D_VALID = dv;
    FLUSH   = fl;
    ERR_CLR = clr;
    PEPKIN  = d;
    @(posedge CLK);
    model_clk();
    #1;
    check_model(tag);
  endtask

  function automatic beat_t mk(input logic [31:0] lo, input bit inc, input logic [7:0] bad);
    beat_t b;
    logic [31:0] w;
    for (int i = 0; i < 8; i++) begin
      w = lo + (inc ? 32'(i) : 32'd0);
      b[i] = {bad[i] ? HI_BAD : w, w};
    end
    return b;
  endfunction

  function automatic beat_t rnd_beat();
    beat_t b;
    logic [31:0] w;
    for (int i = 0; i < 8; i++) begin
      w = $urandom;
      b[i] = {($urandom_range(0, 15) == 0) ? $urandom : w, w};
    end
    return b;
  endfunction

  typedef struct {
    bit dv; bit fl; bit clr;
    logic [31:0] lo; bit inc; logic [7:0] bad;
    bit eqv; bit eqp;
    logic [31:0] ehi; bit ehi_inc; logic [31:0] elo; bit elo_inc;
    logic [7:0] eerr;
  } vec_t;

  vec_t tbl[15];

  task automatic check_zero(input string tag);
    chk({tag, ".pepkout_a"}, out_a, '0);
    chk({tag, ".pepkout_b"}, out_b, '0);
    chk({tag, ".flags"}, {qv_a, qp_a, qv_b, qp_b}, 4'h0);
    chk({tag, ".dup_err"}, {err_a, err_b}, 16'h0);
  endtask

  initial begin
    beat_t eb_a, eb_b, d1, d2;
    int pulses;

    tbl[0]  = '{1,0,0,32'hA0,1,8'h00, 0,0, 32'h0,0,32'h0,0, 8'h00};
    tbl[1]  = '{1,0,0,32'hB0,1,8'h00, 1,0, 32'hB0,1,32'hA0,1, 8'h00};
    tbl[2]  = '{0,0,0,32'h0,0,8'h00, 0,0, 32'h0,0,32'h0,0, 8'h00};
    tbl[3]  = '{1,0,0,32'h1234_5678,0,8'h00, 0,0, 32'h0,0,32'h0,0, 8'h00};
    tbl[4]  = '{0,1,0,32'h0,0,8'h00, 1,1, 32'h0,0,32'h1234_5678,0, 8'h00};
    tbl[5]  = '{1,1,0,32'hC0,1,8'h00, 1,1, 32'h0,0,32'hC0,1, 8'h00};
    tbl[6]  = '{1,0,0,32'hD0,1,8'h00, 0,0, 32'h0,0,32'h0,0, 8'h00};
    tbl[7]  = '{1,1,0,32'hE0,1,8'h00, 1,0, 32'hE0,1,32'hD0,1, 8'h00};
    tbl[8]  = '{0,1,0,32'h0,0,8'h00, 0,0, 32'h0,0,32'h0,0, 8'h00};
    tbl[9]  = '{1,0,0,32'h0,0,8'h08, 0,0, 32'h0,0,32'h0,0, 8'h08};
    tbl[10] = '{1,0,0,32'hF0,1,8'h00, 1,0, 32'hF0,1,32'h0,0, 8'h08};
    tbl[11] = '{0,0,1,32'h0,0,8'h00, 0,0, 32'h0,0,32'h0,0, 8'h00};
    tbl[12] = '{1,0,1,32'h0,0,8'h08, 0,0, 32'h0,0,32'h0,0, 8'h08};
    tbl[13] = '{0,0,1,32'h0,0,8'h00, 0,0, 32'h0,0,32'h0,0, 8'h00};
    tbl[14] = '{1,0,0,32'h10,1,8'h00, 1,0, 32'h10,1,32'h0,0, 8'h00};

    RST = 1'b1; D_VALID = 1'b0; FLUSH = 1'b0; ERR_CLR = 1'b0; PEPKIN = '0;
    model_reset();
    #1;
    check_zero("reset");
    repeat (2) @(posedge CLK);
    #3 RST = 1'b0;

    foreach (tbl[k]) begin
      step(tbl[k].dv, tbl[k].fl, tbl[k].clr, mk(tbl[k].lo, tbl[k].inc, tbl[k].bad),
           $sformatf("row%0d", k));
      chk($sformatf("tbl%0d.q_valid", k), qv_a, tbl[k].eqv);
      chk($sformatf("tbl%0d.q_partial", k), qp_a, tbl[k].eqp);
      chk($sformatf("tbl%0d.dup_err", k), err_a, tbl[k].eerr);
      if (tbl[k].eqv) begin
        for (int i = 0; i < 8; i++) begin
          eb_a[i] = {tbl[k].ehi + (tbl[k].ehi_inc ? 32'(i) : 32'd0),
                     tbl[k].elo + (tbl[k].elo_inc ? 32'(i) : 32'd0)};
          eb_b[i] = tbl[k].eqp ? {PAD_B, eb_a[i][31:0]} : eb_a[i];
        end
        chk($sformatf("tbl%0d.pepkout_a", k), out_a, eb_a);
        chk($sformatf("tbl%0d.pepkout_b", k), out_b, eb_b);
      end
    end

    // Six back-to-back beats: three pulses on alternate cycles.
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      step(1, 0, 0, mk(32'h100 * (k + 1), 1, 8'h00), $sformatf("burst%0d", k));
      if (qv_a) pulses++;
    end
    chk("burst.pulses", pulses, 3);
    chk("burst.last_word", out_a[7], {32'h607, 32'h507});

    // Idle gaps between the two halves of a pair.
    for (int g = 1; g <= 5; g++) begin
      d1 = rnd_beat();
      d2 = rnd_beat();
      step(1, 0, 0, d1, $sformatf("gap%0d.a", g));
      for (int j = 0; j < g; j++) step(0, 0, 0, '0, $sformatf("gap%0d.idle", g));
      step(1, 0, 0, d2, $sformatf("gap%0d.b", g));
      chk($sformatf("gap%0d.lane0", g), out_a[0], {d2[0][31:0], d1[0][31:0]});
    end
    step(0, 0, 1, '0, "clr");

    // Reset while a half-beat is held.
    step(1, 0, 0, mk(32'h77, 1, 8'h00), "pre_rst");
    RST = 1'b1;
    D_VALID = 1'b1;
    #1;
    model_reset();
    check_zero("rst_async");
    @(posedge CLK);
    #1;
    check_zero("rst_held");
    #2 RST = 1'b0;
    step(1, 0, 0, mk(32'h300, 1, 8'h00), "post_rst.a");
    chk("post_rst.no_emit", qv_a, 1'b0);
    step(1, 0, 0, mk(32'h400, 1, 8'h00), "post_rst.b");
    chk("post_rst.lane5", out_a[5], {32'h405, 32'h305});

    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 9) == 0, rnd_beat(), "rand");
    step(0, 1, 0, '0, "drain");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscomp);
    $finish;
  end

endmodule
